// File: rtl/reduce_and_scheduler.sv
// Shares one 8-slot reduction-AND datapath between PORT_NUM requesters.
// Define REDAND_FIXED_PRIO_EN for a fixed-priority arbiter instead of round-robin.
module reduce_and_scheduler #(
    parameter int PORT_NUM = 2,
    parameter int WIDTH    = 8,
    parameter int IDW      = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [PORT_NUM-1:0]       req_valid,
    input  logic [PORT_NUM*WIDTH-1:0] req_data,
    input  logic [PORT_NUM-1:0]       req_last,
    output logic [PORT_NUM-1:0]       req_ready,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [WIDTH-1:0]          res_q,
    output logic [IDW-1:0]            res_id,
    output logic                      busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_RESULT
    } state_t;

    state_t              r_state;
    logic [2:0]          r_cnt;
    logic [WIDTH-1:0]    r_slot [8];
    logic [IDW-1:0]      r_rr_ptr;
    logic [IDW-1:0]      r_grant;
    logic [PORT_NUM-1:0] r_req_ready;
    logic                r_res_valid;
    logic [WIDTH-1:0]    r_res_q;
    logic [IDW-1:0]      r_res_id;
    logic                r_busy;

    logic                w_any;
    logic [IDW-1:0]      w_winner;
    logic                w_beat;
    logic                w_last;
    logic [WIDTH-1:0]    w_data;
    logic [WIDTH-1:0]    w_fold;
    logic                w_and;

`ifdef REDAND_FIXED_PRIO_EN
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_any    = |req_valid;
        w_winner = '0;
        for (int i = PORT_NUM - 1; i >= 0; i--)
            if (req_valid[i]) w_winner = IDW'(i);
    end
`else
    logic [2*PORT_NUM-1:0] w_dbl;
    logic [PORT_NUM-1:0]   w_rot;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    // Rotate the request vector so bit 0 is the port just after rr_ptr.
    always_comb begin
        w_any    = |req_valid;
        w_winner = '0;
        w_dbl    = {req_valid, req_valid} >> (int'(r_rr_ptr) + 1);
        w_rot    = w_dbl[PORT_NUM-1:0];
        for (int i = PORT_NUM - 1; i >= 0; i--)
            if (w_rot[i]) w_winner = IDW'((int'(r_rr_ptr) + 1 + i) % PORT_NUM);
    end
`endif

    assign w_beat = |(req_valid & r_req_ready);
    assign w_last = |(req_last & r_req_ready);

    // Result is folded with the incoming word so it can be registered on the final beat.
    always_comb begin
        w_data = '0;
        for (int i = 0; i < PORT_NUM; i++)
            if (r_req_ready[i]) w_data = req_data[i*WIDTH +: WIDTH];
        w_fold = w_data;
        for (int s = 0; s < 8; s++)
            if (r_cnt != 3'(s)) w_fold = w_fold & r_slot[s];
        w_and = &w_fold;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rr_ptr    <= IDW'(PORT_NUM - 1);
            r_grant     <= '0;
            r_req_ready <= '0;
            r_res_valid <= 1'b0;
            r_res_q     <= '0;
            r_res_id    <= '0;
            r_busy      <= 1'b0;
            // NOTE: the slot array is only 8 flops deep, so it is reset like any other register.
            for (int s = 0; s < 8; s++) r_slot[s] <= '1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant     <= w_winner;
                        r_cnt       <= '0;
                        r_req_ready <= PORT_NUM'(1) << w_winner;
                        r_busy      <= 1'b1;
                        r_state     <= ST_COLLECT;
                        for (int s = 0; s < 8; s++) r_slot[s] <= '1;
                    end
                end
                ST_COLLECT: begin
                    if (w_beat) begin
                        r_slot[r_cnt] <= w_data;
                        r_cnt         <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7 || w_last) begin
                            r_req_ready <= '0;
                            r_res_valid <= 1'b1;
                            r_res_q     <= WIDTH'(w_and);
                            r_res_id    <= r_grant;
                            r_state     <= ST_RESULT;
                        end
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        r_rr_ptr    <= r_grant;
                        r_res_valid <= 1'b0;
                        r_res_q     <= '0;
                        r_res_id    <= '0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign res_valid = r_res_valid;
    assign res_q     = r_res_q;
    assign res_id    = r_res_id;
    assign busy      = r_busy;

endmodule
